icache_ctrl: RTL and testbench

- FSM that sequences a 2-way set-associative instruction cache.
- Drives read/load enables of the per-way data/tag/valid arrays and the shared LRU array from the hit/LRU status the datapath returns.
- On a miss, issues a line fill to physical memory, then re-reads so the CPU receives data from the arrays.
- Sits between the fetch stage (cpu_* handshake), the cache datapath (arrays, tag compare) and the memory arbiter (pmem_*).

---
 rtl/icache_ctrl.sv | 135 +++++++++++++
 tb/tb_icache_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Control FSM for a 2-way set-associative instruction cache: lookup, line fill, re-read.
// Optional saturating hit/miss counters are compiled in with ICACHE_PERF_CTR_EN.
module icache_ctrl #(
    parameter int CTR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cpu_read,
    output logic             o_cpu_resp,
    input  logic             i_hit0,
    input  logic             i_hit1,
    input  logic             i_lru_out,
    output logic             o_array_read,
    output logic [1:0]       o_way_load,
    output logic             o_lru_load,
    output logic             o_lru_in,
    output logic             o_way_sel,
    output logic             o_pmem_read,
    input  logic             i_pmem_resp
`ifdef ICACHE_PERF_CTR_EN
    ,
    output logic [CTR_W-1:0] o_hit_count,
    output logic [CTR_W-1:0] o_miss_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        FILL   = 2'd2,
        REREAD = 2'd3
    } state_t;

    state_t r_state;
    logic   r_victim;
    logic   w_hit;
    logic   w_hit_way;

    if (CTR_W < 1) begin : g_ctr_w_check
        $error("CTR_W must be at least 1");
    end

    assign w_hit     = i_hit0 | i_hit1;
    assign w_hit_way = ~i_hit0;  // way 0 wins when both ways report a hit

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_cpu_resp   = 1'b0;
        o_array_read = 1'b0;
        o_way_load   = 2'b00;
        o_lru_load   = 1'b0;
        o_lru_in     = 1'b0;
        o_way_sel    = 1'b0;
        o_pmem_read  = 1'b0;
        if (!rst) begin
            unique case (r_state)
                IDLE:   o_array_read = i_cpu_read;
                CHECK: begin
                    if (w_hit) begin
                        o_cpu_resp = 1'b1;
                        o_way_sel  = w_hit_way;
                        o_lru_load = 1'b1;
                        o_lru_in   = ~w_hit_way;
                    end
                end
                FILL: begin
                    o_pmem_read = 1'b1;
                    if (i_pmem_resp) begin
                        o_way_load[r_victim] = 1'b1;
                        o_lru_load           = 1'b1;
                        o_lru_in             = ~r_victim;
                    end
                end
                REREAD: o_array_read = 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_victim <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE:   if (i_cpu_read) r_state <= CHECK;
                CHECK: begin
                    if (w_hit) begin
                        r_state <= IDLE;
                    end else begin
                        r_victim <= i_lru_out;
                        r_state  <= FILL;
                    end
                end
                FILL:   if (i_pmem_resp) r_state <= i_cpu_read ? REREAD : IDLE;
                REREAD: r_state <= CHECK;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_CTR_EN
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic             r_refill;
    logic [CTR_W-1:0] r_hit_count;
    logic [CTR_W-1:0] r_miss_count;

    // The refill flag marks the re-check after a fill so it is not counted as a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refill     <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (r_state == REREAD) begin
                r_refill <= 1'b1;
            end else if (r_state == CHECK) begin
                r_refill <= 1'b0;
            end
            if (r_state == CHECK && w_hit && !r_refill && r_hit_count != CTR_MAX) begin
                r_hit_count <= r_hit_count + CTR_W'(1);
            end
            if (r_state == CHECK && !w_hit && r_miss_count != CTR_MAX) begin
                r_miss_count <= r_miss_count + CTR_W'(1);
            end
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed reset/hit/miss/drop cases plus randomized transactions,
// each cycle compared against an expected-output trace derived from transaction timing.
module tb_icache_ctrl;

    localparam int CTR_W   = 3;
    localparam int CTR_MAX = (1 << CTR_W) - 1;

    typedef struct packed {
        logic       cpu_resp;
        logic       array_read;
        logic [1:0] way_load;
        logic       lru_load;
        logic       lru_in;
        logic       way_sel;
        logic       pmem_read;
    } outs_t;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       cpu_read  = 1'b1;
    logic       hit0      = 1'b1;
    logic       hit1      = 1'b1;
    logic       lru_out   = 1'b0;
    logic       pmem_resp = 1'b1;
    logic       cpu_resp;
    logic       array_read;
    logic [1:0] way_load;
    logic       lru_load;
    logic       lru_in;
    logic       way_sel;
    logic       pmem_read;
`ifdef ICACHE_PERF_CTR_EN
    logic [CTR_W-1:0] hit_count;
    logic [CTR_W-1:0] miss_count;
`endif

    int n_checks   = 0;
    int n_pass     = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    icache_ctrl #(.CTR_W(CTR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cpu_read   (cpu_read),
        .o_cpu_resp   (cpu_resp),
        .i_hit0       (hit0),
        .i_hit1       (hit1),
        .i_lru_out    (lru_out),
        .o_array_read (array_read),
        .o_way_load   (way_load),
        .o_lru_load   (lru_load),
        .o_lru_in     (lru_in),
        .o_way_sel    (way_sel),
        .o_pmem_read  (pmem_read),
        .i_pmem_resp  (pmem_resp)
`ifdef ICACHE_PERF_CTR_EN
        ,
        .o_hit_count  (hit_count),
        .o_miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int sat(input int v);
        return (v > CTR_MAX) ? CTR_MAX : v;
    endfunction

    function automatic outs_t observed();
        observed = {cpu_resp, array_read, way_load, lru_load, lru_in, way_sel, pmem_read};
    endfunction

    // Expected-output patterns, one per kind of cycle in a transaction.
    function automatic outs_t o_zero();
        return '0;
    endfunction

    function automatic outs_t o_arr();
        outs_t e;
        e = '0;
        e.array_read = 1'b1;
        return e;
    endfunction

    function automatic outs_t o_hit(input logic way);
        outs_t e;
        e = '0;
        e.cpu_resp = 1'b1;
        e.way_sel  = way;
        e.lru_load = 1'b1;
        e.lru_in   = ~way;
        return e;
    endfunction

    function automatic outs_t o_fill(input logic done, input logic v);
        outs_t e;
        e = '0;
        e.pmem_read = 1'b1;
        if (done) begin
            e.way_load = v ? 2'b10 : 2'b01;
            e.lru_load = 1'b1;
            e.lru_in   = ~v;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input outs_t exp);
        check(tag, 32'(observed()), 32'(exp));
`ifdef ICACHE_PERF_CTR_EN
        check({tag, "/hit_count"}, 32'(hit_count), 32'(sat(exp_hits)));
        check({tag, "/miss_count"}, 32'(miss_count), 32'(sat(exp_misses)));
`endif
    endtask

    // One clock cycle: drive inputs at the falling edge, compare shortly after.
    task automatic cyc(input logic cr, input logic h0, input logic h1, input logic lo,
                       input logic pr, input outs_t exp, input string tag);
        @(negedge clk);
        cpu_read  = cr;
        hit0      = h0;
        hit1      = h1;
        lru_out   = lo;
        pmem_resp = pr;
        #1;
        check_all(tag, exp);
    endtask

    task automatic run_hit(input logic h0, input logic h1, input bit skip_req);
        logic way;
        way = h0 ? 1'b0 : 1'b1;
        if (!skip_req) cyc(1'b1, rb(), rb(), rb(), rb(), o_arr(), "hit_req");
        cyc(rb(), h0, h1, rb(), rb(), o_hit(way), "hit_check");
        exp_hits++;
    endtask

    // Miss: request at cycle 0, CHECK miss at 1, fill response at cycle n.
    task automatic run_miss(input logic v, input int n, input bit drop, input int drop_at);
        cyc(1'b1, rb(), rb(), rb(), rb(), o_arr(), "miss_req");
        cyc(rb(), 1'b0, 1'b0, v, rb(), o_zero(), "miss_check");
        exp_misses++;
        for (int c = 2; c <= n; c++) begin
            logic cr;
            cr = (drop && c >= drop_at) ? 1'b0 : 1'b1;
            if (c == n) cyc(cr, rb(), rb(), rb(), 1'b1, o_fill(1'b1, v), "fill_resp");
            else        cyc(cr, rb(), rb(), rb(), 1'b0, o_fill(1'b0, v), "fill_wait");
        end
        if (drop) begin
            cyc(1'b0, rb(), rb(), rb(), rb(), o_zero(), "dropped_idle");
        end else begin
            cyc(rb(), rb(), rb(), rb(), rb(), o_arr(), "reread");
            cyc(rb(), ~v, v, rb(), rb(), o_hit(v), "refill_hit");
        end
    endtask

    initial begin
        // Reset held with requests and fill responses active: outputs stay low.
        repeat (3) cyc(1'b1, 1'b1, 1'b1, rb(), 1'b1, o_zero(), "reset_hold");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("reset_release", o_arr());

        // Directed hit in way 1 continuing the request above.
        run_hit(1'b0, 1'b1, 1'b1);
        cyc(1'b0, rb(), rb(), rb(), rb(), o_zero(), "idle_after_hit");

        // Directed miss, victim way 1, fill response in cycle 5.
        run_miss(1'b1, 5, 1'b0, 0);
        cyc(1'b0, rb(), rb(), rb(), rb(), o_zero(), "idle_after_miss");

        // Request dropped during FILL: cpu_read low from cycle 3, response in cycle 4.
        run_miss(1'b0, 4, 1'b1, 3);

        // Reset asserted in the middle of a fill.
        cyc(1'b1, rb(), rb(), rb(), rb(), o_arr(), "rstfill_req");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, rb(), o_zero(), "rstfill_miss");
        exp_misses++;
        cyc(1'b1, rb(), rb(), rb(), 1'b0, o_fill(1'b0, 1'b1), "rstfill_wait");
        @(negedge clk);
        cpu_read  = 1'b1;
        pmem_resp = 1'b0;
        #1;
        check_all("rstfill_pre", o_fill(1'b0, 1'b1));
        rst        = 1'b1;
        exp_hits   = 0;
        exp_misses = 0;
        #1;
        check_all("rstfill_async", o_zero());
        cyc(1'b1, rb(), rb(), rb(), 1'b1, o_zero(), "rstfill_held");
        @(negedge clk);
        cpu_read  = 1'b0;
        pmem_resp = 1'b1;
        rst       = 1'b0;
        #1;
        check_all("rstfill_released", o_zero());
        run_miss(1'b0, 3, 1'b0, 0);

        // Randomized transaction mix with random idle gaps.
        for (int t = 0; t < 40; t++) begin
            int gap;
            if (rb()) begin
                logic [1:0] hv;
                hv = 2'($urandom_range(1, 3));
                run_hit(hv[1], hv[0], 1'b0);
            end else begin
                int n;
                n = $urandom_range(2, 6);
                run_miss(rb(), n, ($urandom_range(0, 3) == 0), $urandom_range(2, n));
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) cyc(1'b0, rb(), rb(), rb(), rb(), o_zero(), "gap_idle");
        end

        // Enough back-to-back hits to saturate the counter, then a dual-way hit.
        for (int k = 0; k < 9; k++) run_hit(1'b0, 1'b1, 1'b0);
        run_hit(1'b1, 1'b1, 1'b0);
        cyc(1'b0, rb(), rb(), rb(), rb(), o_zero(), "final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
